// File: rtl/mango2_disp_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
package mango2_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } bcd_state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
// bringing in the next binary bit. Purely combinational.
module bcd_dd_step
    import mango2_disp_pkg::*;
(
    input  logic [BCD_DIGITS*4-1:0] bcd_in,
    input  logic                    msb,
    output logic [BCD_DIGITS*4-1:0] bcd_out
);

    localparam int BCD_W = BCD_DIGITS * 4;

    logic [BCD_W-1:0] adj;

    // Correct each digit that would overflow past 9 once doubled.
    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_in[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is dropped; only reachable on overflow inputs.
    assign bcd_out = BCD_W'({adj, msb});

endmodule

// File: rtl/bin2bcd_disp.sv
// Sequential binary-to-BCD converter feeding the 4-digit seven-segment driver.
// Converts one value in BIN_W cycles and holds the result stable between updates.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for in_valid; in_ready=1
// S_SHIFT | one double-dabble step per cycle, BIN_W cycles in total
// S_DONE  | result registered; out_valid=1 for this single cycle
module bin2bcd_disp
    import mango2_disp_pkg::*;
#(
    parameter int          BIN_W    = 14,
    parameter logic [15:0] OVF_CODE = 16'hEEEE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] bin,
    output logic [15:0]      value,
    output logic             ovf,
    output logic             out_valid
);

    localparam int                BCD_W = BCD_DIGITS * 4;
    localparam int                CW    = $clog2(BIN_W + 1);
    localparam logic [CW-1:0]     LAST  = CW'(BIN_W - 1);

    bcd_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_step;
    logic             ovf_n;
    logic             bin_ovf;

    // For narrow BIN_W this compare folds to constant 0, so ovf never sets.
    assign bin_ovf = (32'(bin) > 32'(BCD_MAX));

    bcd_dd_step u_step (
        .bcd_in  (bcd),
        .msb     (shreg[BIN_W-1]),
        .bcd_out (bcd_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs, all decoded from state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load on accept, step during SHIFT, publish result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
            bcd   <= '0;
            ovf_n <= 1'b0;
            value <= 16'h0000;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg <= bin;
                        bcd   <= '0;
                        cnt   <= '0;
                        ovf_n <= bin_ovf;
                    end
                end
                S_SHIFT: begin
                    bcd   <= bcd_step;
                    shreg <= shreg << 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        value <= ovf_n ? OVF_CODE : bcd_step;
                        ovf   <= ovf_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
